lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 40 ++++
 rtl/lcd_timing_pipe.sv | 34 +++
 rtl/lcd_timing_gen.sv | 181 ++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types for the LCD raster timing generator: register map,
// timing field bundle and the power-on timing set.
package lcd_timing_pkg;

  localparam int CNT_W_DEF = 12;

  typedef enum logic [2:0] {
    CFG_H_FRONT = 3'd0,
    CFG_H_SYNC  = 3'd1,
    CFG_H_BACK  = 3'd2,
    CFG_H_ACT   = 3'd3,
    CFG_V_FRONT = 3'd4,
    CFG_V_SYNC  = 3'd5,
    CFG_V_BACK  = 3'd6,
    CFG_V_ACT   = 3'd7
  } cfg_addr_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] v_act;
    logic [CNT_W_DEF-1:0] v_back;
    logic [CNT_W_DEF-1:0] v_sync;
    logic [CNT_W_DEF-1:0] v_front;
    logic [CNT_W_DEF-1:0] h_act;
    logic [CNT_W_DEF-1:0] h_back;
    logic [CNT_W_DEF-1:0] h_sync;
    logic [CNT_W_DEF-1:0] h_front;
  } lcd_timing_t;

  localparam lcd_timing_t TIMING_DEFAULT = '{
    v_act:   12'd480,
    v_back:  12'd7,
    v_sync:  12'd10,
    v_front: 12'd3,
    h_act:   12'd800,
    h_back:  12'd96,
    h_sync:  12'd72,
    h_front: 12'd24
  };

endpackage

// File: rtl/lcd_timing_pipe.sv
// Tick-enabled delay line of DEPTH stages, each resetting to RST.
// Used to align the raster outputs with the downstream pixel path.
module lcd_timing_pipe #(
  parameter int           W     = 1,
  parameter int           DEPTH = 1,
  parameter logic [W-1:0] RST   = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stg_q, stg_d;

  always_comb begin
    stg_d = stg_q;
    if (tick) begin
      stg_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stg_q <= {DEPTH{RST}};
    else       stg_q <= stg_d;
  end

  assign q = stg_q[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// h/v raster generator with delayed sync/enable/position outputs.
// Define LCD_TIMING_PROG_EN for the shadow/active timing register port.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CNT_W          = 12,
  parameter int X_W            = 10,
  parameter int Y_W            = 10,
  parameter int PIPE_DELAY     = 1,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int H_FRONT        = 24,
  parameter int H_SYNC         = 72,
  parameter int H_BACK         = 96,
  parameter int H_ACT          = 800,
  parameter int V_FRONT        = 3,
  parameter int V_SYNC         = 10,
  parameter int V_BACK         = 7,
  parameter int V_ACT          = 480
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             cfg_pending,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             hs,
  output logic             vs,
  output logic             data_enable,
  output logic             line_start,
  output logic             next_frame
);

  localparam int   HW    = CNT_W + 2;
  localparam int   OW    = X_W + Y_W + 5;
  localparam logic HS_ON = (HS_ACTIVE_HIGH != 0);
  localparam logic VS_ON = (VS_ACTIVE_HIGH != 0);

  typedef logic [7:0][CNT_W-1:0] tim_t;

  function automatic logic [CNT_W-1:0] clamp_act(
    input logic [CNT_W-1:0] a
  );
    return (a == '0) ? CNT_W'(1) : a;
  endfunction

  localparam tim_t TIM_RST = {
    clamp_act(CNT_W'(V_ACT)), CNT_W'(V_BACK),
    CNT_W'(V_SYNC), CNT_W'(V_FRONT),
    clamp_act(CNT_W'(H_ACT)), CNT_W'(H_BACK),
    CNT_W'(H_SYNC), CNT_W'(H_FRONT)
  };

  localparam logic [OW-1:0] OUT_RST = {
    X_W'(0), Y_W'(0), ~HS_ON, ~VS_ON, 3'b000
  };

  tim_t          tim;
  logic [HW-1:0] h_q, h_d, v_q, v_d;
  logic [HW-1:0] hf, hse, hb, ht;
  logic [HW-1:0] vf, vse, vb, vt;
  logic          h_last, v_last, wrap;
  logic          in_hs, in_vs, de;
  logic [X_W-1:0] dec_x;
  logic [Y_W-1:0] dec_y;
  logic [OW-1:0]  dec, out_q;

  always_comb begin
    hf     = HW'(tim[CFG_H_FRONT]);
    hse    = hf  + HW'(tim[CFG_H_SYNC]);
    hb     = hse + HW'(tim[CFG_H_BACK]);
    ht     = hb  + HW'(tim[CFG_H_ACT]);
    vf     = HW'(tim[CFG_V_FRONT]);
    vse    = vf  + HW'(tim[CFG_V_SYNC]);
    vb     = vse + HW'(tim[CFG_V_BACK]);
    vt     = vb  + HW'(tim[CFG_V_ACT]);
    h_last = (h_q == ht - HW'(1));
    v_last = (v_q == vt - HW'(1));
    wrap   = h_last && v_last;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + HW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

`ifdef LCD_TIMING_PROG_EN
  tim_t shd_q, shd_d, act_q, act_d;
  logic pend_q, pend_d;

  // Copy reads the pre-write shadow, so a write on the wrap waits a frame.
  always_comb begin
    shd_d  = shd_q;
    act_d  = act_q;
    pend_d = pend_q;
    if (tick && wrap) begin
      act_d            = shd_q;
      act_d[CFG_H_ACT] = clamp_act(shd_q[CFG_H_ACT]);
      act_d[CFG_V_ACT] = clamp_act(shd_q[CFG_V_ACT]);
      pend_d           = 1'b0;
    end
    if (cfg_we) begin
      shd_d[cfg_addr] = cfg_data;
      pend_d          = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shd_q  <= TIM_RST;
      act_q  <= TIM_RST;
      pend_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

  assign tim         = act_q;
  assign cfg_pending = pend_q;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{cfg_we, cfg_addr, cfg_data, wrap};
  assign tim         = TIM_RST;
  assign cfg_pending = 1'b0;
`endif

  always_comb begin
    in_hs = (h_q >= hf) && (h_q < hse);
    in_vs = (v_q >= vf) && (v_q < vse);
    de    = (h_q >= hb) && (v_q >= vb);
    dec_x = de ? X_W'(h_q - hb) : '0;
    dec_y = de ? Y_W'(v_q - vb) : '0;
    dec   = {
      dec_x, dec_y,
      in_hs ? HS_ON : ~HS_ON,
      in_vs ? VS_ON : ~VS_ON,
      de,
      de && (h_q == hb),
      (h_q == '0) && (v_q == vf)
    };
  end

  lcd_timing_pipe #(
    .W     (OW),
    .DEPTH (PIPE_DELAY),
    .RST   (OUT_RST)
  ) u_pipe (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .d     (dec),
    .q     (out_q)
  );

  assign {x, y, hs, vs, data_enable, line_start, next_frame} = out_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomised scoreboard bench for lcd_timing_gen against a
// frame-level reference model of the raster rules.
module tb_lcd_timing_gen;

  localparam int PD = 3;

`ifdef LCD_TIMING_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       nf;
  } obs_t;

  // hs active-low (idle 1), vs active-high (idle 0)
  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, hs: 1'b1,
                               vs: 1'b0, de: 1'b0, ls: 1'b0,
                               nf: 1'b0};

  logic        clk = 1'b0;
  logic        rst, tick, we;
  logic [2:0]  addr;
  logic [11:0] data;
  logic        cfg_pending;
  logic [9:0]  x, y;
  logic        hs, vs, de, ls, nf;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .CNT_W(12), .X_W(10), .Y_W(10), .PIPE_DELAY(PD),
    .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(1),
    .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .H_ACT(4),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(0), .V_ACT(3)
  ) dut (
    .clock(clk), .reset(rst), .tick(tick),
    .cfg_we(we), .cfg_addr(addr), .cfg_data(data),
    .cfg_pending(cfg_pending),
    .x(x), .y(y), .hs(hs), .vs(vs),
    .data_enable(de), .line_start(ls), .next_frame(nf)
  );

  int   nvec = 0;
  int   nerr = 0;
  obs_t sb[$];
  int   tim[8];
  int   shd[8];
  bit   pend;
  int   mh, mv;
  int   DEF[8] = '{1, 1, 1, 4, 1, 1, 0, 3};

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int htot();
    return tim[0] + tim[1] + tim[2] + tim[3];
  endfunction

  function automatic int vtot();
    return tim[4] + tim[5] + tim[6] + tim[7];
  endfunction

  // What the raster looks like at pixel (h, v) under the active timing
  function automatic obs_t decode(input int h, input int v);
    obs_t o;
    int   hb, vb;
    bit   ihs, ivs;
    hb   = tim[0] + tim[1] + tim[2];
    vb   = tim[4] + tim[5] + tim[6];
    ihs  = (h >= tim[0]) && (h < tim[0] + tim[1]);
    ivs  = (v >= tim[4]) && (v < tim[4] + tim[5]);
    o.de = (h >= hb) && (v >= vb);
    o.x  = o.de ? 10'(h - hb) : 10'd0;
    o.y  = o.de ? 10'(v - vb) : 10'd0;
    o.hs = !ihs;
    o.vs = ivs;
    o.ls = o.de && (h == hb);
    o.nf = (h == 0) && (v == tim[4]);
    return o;
  endfunction

  task automatic model_reset();
    tim  = DEF;
    shd  = DEF;
    pend = 1'b0;
    mh   = 0;
    mv   = 0;
    sb.delete();
    repeat (PD - 1) sb.push_back(RST_OBS);
  endtask

  task automatic step(input bit t, input bit w, input int a, input int d);
    bit wr;
    wr = 1'b0;
    if (t) begin
      sb.push_back(decode(mh, mv));
      if (mh == htot() - 1) begin
        mh = 0;
        if (mv == vtot() - 1) begin
          mv = 0;
          wr = 1'b1;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      if (wr && PROG) begin
        tim = shd;
        if (tim[3] == 0) tim[3] = 1;
        if (tim[7] == 0) tim[7] = 1;
        pend = 1'b0;
      end
    end
    if (w && PROG) begin
      shd[a] = d;
      pend   = 1'b1;
    end
  endtask

  obs_t last_o;

  always @(posedge clk) begin
    logic t, r;
    obs_t o, e;
    t = tick;
    r = rst;
    #1;
    o = {x, y, hs, vs, de, ls, nf};
    if (r) begin
      check("reset_out", 32'(o), 32'(RST_OBS));
      check("reset_pending", 32'(cfg_pending), 32'd0);
    end else begin
      if (t) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("tick_out", 32'(o), 32'(e));
        end
      end else begin
        check("hold_out", 32'(o), 32'(last_o));
      end
      check("cfg_pending", 32'(cfg_pending), 32'(pend));
    end
    last_o = o;
  end

  initial begin
    bit near;
    rst  = 1'b1;
    tick = 1'b0;
    we   = 1'b0;
    addr = 3'd0;
    data = 12'd0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        rst  = 1'b1;
        tick = 1'b0;
        we   = 1'b0;
        model_reset();
      end else begin
        rst  = 1'b0;
        near = (mh == htot() - 1) && (mv == vtot() - 1);
        tick = ($urandom_range(0, 2) != 0);
        if (near && tick) we = ($urandom_range(0, 1) == 1);
        else              we = ($urandom_range(0, 39) == 0);
        addr = 3'($urandom_range(0, 7));
        data = 12'($urandom_range(0, 5));
        step(tick, we, int'(addr), int'(data));
      end
    end
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    we   = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
